// File: rtl/avmm_pkg.sv
// Shared types and helpers for the Avalon-MM memory responder.
// Covers the default bus widths, the power-up memory pattern and the address legality check.
package avmm_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 32;

  typedef logic [63:0] word_t;

  // Each byte of word idx holds idx+1, so a dump shows the word index at a glance.
  function automatic word_t init_word(input int idx);
    logic [7:0] b;
    b = 8'(idx + 1);
    return {8{b}};
  endfunction

  // A legal address is 8-byte aligned and selects one of the depth words.
  function automatic logic addr_ok(input logic [63:0] addr, input int depth);
    return (addr[2:0] == 3'b000) && ((addr >> 3) < 64'(depth));
  endfunction

endpackage

// File: rtl/rd_delay_pipe.sv
// Fixed-latency delay line for read responses: {valid, data} shifted one stage per clock.
// Stage 0 is loaded at the read accept edge.
module rd_delay_pipe #(
  parameter int LATENCY = 4,
  parameter int DATA_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [LATENCY-1:0] valid_q;
  logic [DATA_W-1:0]  data_q [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/avmm_mem_responder.sv
// Avalon-MM slave memory model with pipelined fixed-latency reads and single-cycle writes.
// The number of outstanding reads is bounded through waitrequest.
module avmm_mem_responder
  import avmm_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = 16,
  parameter int LATENCY  = 4,
  parameter int MAX_PEND = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic              waitrequest,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  input  logic              stall,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(MAX_PEND + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  pend_cnt;
  logic [IDX_W-1:0]  word_idx;
  logic              in_range;
  logic              rd_acc;
  logic              wr_acc;
  logic              conflict;
  logic [DATA_W-1:0] rd_word;
  logic              pipe_valid;
  logic [DATA_W-1:0] pipe_data;

  assign word_idx = address[IDX_W+2:3];
  assign in_range = addr_ok(64'(address), DEPTH);

  // Only registered state and the stall hook feed waitrequest; read/write never reach it.
  assign waitrequest = stall | (pend_cnt == CNT_W'(MAX_PEND));

  assign conflict = read & write;
  assign rd_acc   = read & ~write & ~waitrequest;
  assign wr_acc   = write & ~read & ~waitrequest;
  assign rd_word  = in_range ? mem[word_idx] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(init_word(i));
      end
    end else if (wr_acc && in_range) begin
      mem[word_idx] <= writedata;
    end
  end

  rd_delay_pipe #(
    .LATENCY (LATENCY),
    .DATA_W  (DATA_W)
  ) u_rd_delay_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_acc),
    .in_data   (rd_word),
    .out_valid (pipe_valid),
    .out_data  (pipe_data)
  );

  // A response leaving the pipe this edge frees its slot in the same edge it is emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_cnt <= '0;
    end else begin
      case ({rd_acc, pipe_valid})
        2'b10:   pend_cnt <= pend_cnt + CNT_W'(1);
        2'b01:   pend_cnt <= pend_cnt - CNT_W'(1);
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      readdatavalid <= 1'b0;
      readdata      <= '0;
    end else begin
      readdatavalid <= pipe_valid;
      if (pipe_valid) begin
        readdata <= pipe_data;
      end
    end
  end

  // Range errors count only for accepted transfers; a read/write collision always counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (conflict || ((rd_acc || wr_acc) && !in_range)) begin
      err <= 1'b1;
    end
  end

endmodule
